// File: rtl/cpu_keys_pkg.sv
// Key codes and sequencer state encoding shared by the keypad sequencer,
// the CPU top level and the LCD block.
package cpu_keys_pkg;

  localparam logic [7:0] KEY_DIGIT_MAX = 8'd9;
  localparam logic [7:0] KEY_OP_MIN    = 8'd20;
  localparam logic [7:0] KEY_OP_MAX    = 8'd23;
  localparam logic [7:0] KEY_ENTER     = 8'd26;
  localparam logic [7:0] KEY_EQ        = 8'd27;
  localparam logic [7:0] KEY_CLR       = 8'd28;

  // Encodings double as the 7-seg state display codes.
  typedef enum logic [7:0] {
    ST_OP1   = 8'd1,
    ST_OP2   = 8'd2,
    ST_ASM   = 8'd3,
    ST_READY = 8'd4,
    ST_RUN   = 8'd5,
    ST_DONE  = 8'd6,
    ST_ERR   = 8'd14
  } state_t;

  function automatic logic is_digit(input logic [7:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_operator(input logic [7:0] code);
    return (code >= KEY_OP_MIN) && (code <= KEY_OP_MAX);
  endfunction

endpackage

// File: rtl/operand_accumulator.sv
// Two-digit decimal operand builder: shifts in up to two digits, ignores
// further digits until cleared or restarted with a fresh first digit.
module operand_accumulator
  import cpu_keys_pkg::*;
#(
  parameter int Data_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_restart,
  input  logic [3:0]            i_digit,
  output logic [Data_WIDTH-1:0] o_value,
  output logic [1:0]            o_count
);

  logic [Data_WIDTH-1:0] r_value;
  logic [1:0]            r_count;

  always_ff @(posedge i_clock) begin
    if (!i_rst_n || i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_restart) begin
      r_value <= Data_WIDTH'(i_digit);
      r_count <= 2'd1;
    end else if (i_load && (r_count < 2'd2)) begin
      // Two digits at most keeps the value <= 99, so no overflow handling.
      r_value <= r_value * Data_WIDTH'(10) + Data_WIDTH'(i_digit);
      r_count <= r_count + 2'd1;
    end
  end

  assign o_value = r_value;
  assign o_count = r_count;

endmodule

// File: rtl/keypad_sequencer.sv
// Turns key strobes into operands/operator and sequences the CPU run:
// assembler enable, then control-unit enable with done handshake and timeout.
//
// state | meaning
// OP1   | collecting digits of operand1, waiting for an operator key
// OP2   | collecting digits of operand2, waiting for Enter
// ASM   | assembler_en held for ASM_CYCLES cycles
// READY | assembled, waiting for '='
// RUN   | control_u_en high, waiting for armed cu_done or timeout
// DONE  | result latched; a digit starts a new calculation
// ERR   | control unit timed out; only Clear or reset leaves
module keypad_sequencer
  import cpu_keys_pkg::*;
#(
  parameter int Data_WIDTH = 8,
  parameter int ASM_CYCLES = 16,
  parameter int CU_TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  globalReset_n,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  input  logic                  cu_done,
  input  logic [Data_WIDTH-1:0] cu_result,
  output logic [Data_WIDTH-1:0] operand1,
  output logic [Data_WIDTH-1:0] operand2,
  output logic [7:0]            operator,
  output logic                  assembler_en,
  output logic                  control_u_en,
  output logic                  soft_reset,
  output logic [Data_WIDTH-1:0] result,
  output logic [7:0]            state,
  output logic                  busy,
  output logic                  error
);

  localparam int CNT_MAX = (CU_TIMEOUT > ASM_CYCLES) ? CU_TIMEOUT : ASM_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ASM_LOAD = CNT_W'(ASM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(CU_TIMEOUT - 1);

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_armed, w_armed_nxt;
  logic [7:0]            r_operator, w_operator_nxt;
  logic [Data_WIDTH-1:0] r_result, w_result_nxt;
  logic                  r_asm_en, r_cu_en, r_soft_reset, r_busy, r_error;

  logic                  w_key_digit, w_key_op, w_key_enter, w_key_eq, w_key_clr;
  logic                  w_op1_load, w_op1_clear, w_op1_restart;
  logic                  w_op2_load, w_op2_clear;
  logic [1:0]            w_op1_count, w_op2_count;
  logic [3:0]            w_digit;

  assign w_key_digit = key_valid && is_digit(key_code);
  assign w_key_op    = key_valid && is_operator(key_code);
  assign w_key_enter = key_valid && (key_code == KEY_ENTER);
  assign w_key_eq    = key_valid && (key_code == KEY_EQ);
  assign w_key_clr   = key_valid && (key_code == KEY_CLR);
  assign w_digit     = key_code[3:0];

  operand_accumulator #(.Data_WIDTH(Data_WIDTH)) u_operand1 (
    .i_clock   (clock),
    .i_rst_n   (globalReset_n),
    .i_clear   (w_op1_clear),
    .i_load    (w_op1_load),
    .i_restart (w_op1_restart),
    .i_digit   (w_digit),
    .o_value   (operand1),
    .o_count   (w_op1_count)
  );

  operand_accumulator #(.Data_WIDTH(Data_WIDTH)) u_operand2 (
    .i_clock   (clock),
    .i_rst_n   (globalReset_n),
    .i_clear   (w_op2_clear),
    .i_load    (w_op2_load),
    .i_restart (1'b0),
    .i_digit   (w_digit),
    .o_value   (operand2),
    .o_count   (w_op2_count)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_armed_nxt    = r_armed;
    w_operator_nxt = r_operator;
    w_result_nxt   = r_result;
    w_op1_load     = 1'b0;
    w_op1_clear    = 1'b0;
    w_op1_restart  = 1'b0;
    w_op2_load     = 1'b0;
    w_op2_clear    = 1'b0;

    if (w_key_clr) begin
      // Clear overrides everything, including an in-flight ASM or RUN.
      w_state_nxt    = ST_OP1;
      w_cnt_nxt      = '0;
      w_armed_nxt    = 1'b0;
      w_operator_nxt = '0;
      w_result_nxt   = '0;
      w_op1_clear    = 1'b1;
      w_op2_clear    = 1'b1;
    end else begin
      unique case (r_state)
        ST_OP1: begin
          if (w_key_digit) begin
            w_op1_load = 1'b1;
          end else if (w_key_op && (w_op1_count != 2'd0)) begin
            w_operator_nxt = key_code;
            w_state_nxt    = ST_OP2;
          end
        end
        ST_OP2: begin
          if (w_key_digit) begin
            w_op2_load = 1'b1;
          end else if (w_key_enter && (w_op2_count != 2'd0)) begin
            w_cnt_nxt   = ASM_LOAD;
            w_state_nxt = ST_ASM;
          end
        end
        ST_ASM: begin
          if (r_cnt == '0) w_state_nxt = ST_READY;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        ST_READY: begin
          if (w_key_eq) begin
            w_cnt_nxt   = RUN_LOAD;
            w_armed_nxt = 1'b0;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          // A done level left over from a previous run is not trusted until
          // cu_done has been seen low at least once in this run.
          if (r_armed && cu_done) begin
            w_result_nxt = cu_result;
            w_state_nxt  = ST_DONE;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
          if (!cu_done) w_armed_nxt = 1'b1;
        end
        ST_DONE: begin
          if (w_key_digit) begin
            w_op1_restart  = 1'b1;
            w_op2_clear    = 1'b1;
            w_operator_nxt = '0;
            w_state_nxt    = ST_OP1;
          end
        end
        ST_ERR: begin
          w_state_nxt = ST_ERR;
        end
        default: begin
          w_state_nxt = ST_OP1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!globalReset_n) begin
      r_state      <= ST_OP1;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
      r_operator   <= '0;
      r_result     <= '0;
      r_asm_en     <= 1'b0;
      r_cu_en      <= 1'b0;
      r_soft_reset <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_armed      <= w_armed_nxt;
      r_operator   <= w_operator_nxt;
      r_result     <= w_result_nxt;
      // Status flags come from the next state so they change with it.
      r_asm_en     <= (w_state_nxt == ST_ASM);
      r_cu_en      <= (w_state_nxt == ST_RUN);
      r_busy       <= (w_state_nxt == ST_ASM) || (w_state_nxt == ST_RUN);
      r_error      <= (w_state_nxt == ST_ERR);
      r_soft_reset <= w_key_clr;
    end
  end

  assign operator     = r_operator;
  assign result       = r_result;
  assign state        = r_state;
  assign assembler_en = r_asm_en;
  assign control_u_en = r_cu_en;
  assign soft_reset   = r_soft_reset;
  assign busy         = r_busy;
  assign error        = r_error;

endmodule

// File: tb/tb_keypad_sequencer.sv
// Bench for keypad_sequencer: directed scenarios plus random key streams,
// every cycle compared against a digit-queue / timestamp reference model.
module tb_keypad_sequencer;

  localparam int DW    = 8;
  localparam int ASM_N = 16;
  localparam int CU_TO = 1024;

  logic          clock = 1'b0;
  logic          globalReset_n;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          cu_done;
  logic [DW-1:0] cu_result;
  logic [DW-1:0] operand1, operand2, result;
  logic [7:0]    operator, state;
  logic          assembler_en, control_u_en, soft_reset, busy, error;

  always #5 clock = ~clock;

  keypad_sequencer #(.Data_WIDTH(DW), .ASM_CYCLES(ASM_N), .CU_TIMEOUT(CU_TO)) dut (
    .clock         (clock),
    .globalReset_n (globalReset_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .cu_done       (cu_done),
    .cu_result     (cu_result),
    .operand1      (operand1),
    .operand2      (operand2),
    .operator      (operator),
    .assembler_en  (assembler_en),
    .control_u_en  (control_u_en),
    .soft_reset    (soft_reset),
    .result        (result),
    .state         (state),
    .busy          (busy),
    .error         (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase holds the display code, operands are digit queues,
  // ASM/RUN durations come from the cycle number at which they were entered.
  int m_phase;
  int q1[$];
  int q2[$];
  int m_oper, m_result, t_mark, cyc;
  bit m_soft, m_seen_zero;
  logic drv_done;

  function automatic int digits_value(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  task automatic model_clear();
    q1.delete();
    q2.delete();
    m_oper = 0;
    m_result = 0;
    m_seen_zero = 0;
  endtask

  task automatic model_step(input logic rst_n, input logic kv, input logic [7:0] kc,
                            input logic done, input logic [7:0] res);
    int k;
    bit dig;
    k = int'(kc);
    dig = kv && (k <= 9);
    m_soft = 0;
    if (!rst_n) begin
      m_phase = 1;
      model_clear();
      return;
    end
    if (kv && k == 28) begin
      m_soft = 1;
      m_phase = 1;
      model_clear();
      return;
    end
    case (m_phase)
      1: begin
        if (dig) begin
          if (q1.size() < 2) q1.push_back(k);
        end else if (kv && k >= 20 && k <= 23 && q1.size() > 0) begin
          m_oper = k;
          m_phase = 2;
        end
      end
      2: begin
        if (dig) begin
          if (q2.size() < 2) q2.push_back(k);
        end else if (kv && k == 26 && q2.size() > 0) begin
          m_phase = 3;
          t_mark = cyc;
        end
      end
      3: if (cyc - t_mark == ASM_N) m_phase = 4;
      4: begin
        if (kv && k == 27) begin
          m_phase = 5;
          t_mark = cyc;
          m_seen_zero = 0;
        end
      end
      5: begin
        if (m_seen_zero && done) begin
          m_result = int'(res);
          m_phase = 6;
        end else if (cyc - t_mark == CU_TO) begin
          m_phase = 14;
        end
        if (!done) m_seen_zero = 1;
      end
      6: begin
        if (dig) begin
          q1.delete();
          q1.push_back(k);
          q2.delete();
          m_oper = 0;
          m_phase = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_val("state", 32'(state), m_phase);
    check_val("operand1", 32'(operand1), digits_value(q1));
    check_val("operand2", 32'(operand2), digits_value(q2));
    check_val("operator", 32'(operator), m_oper);
    check_val("result", 32'(result), m_result);
    check_val("assembler_en", 32'(assembler_en), 32'(m_phase == 3));
    check_val("control_u_en", 32'(control_u_en), 32'(m_phase == 5));
    check_val("busy", 32'(busy), 32'(m_phase == 3 || m_phase == 5));
    check_val("error", 32'(error), 32'(m_phase == 14));
    check_val("soft_reset", 32'(soft_reset), 32'(m_soft));
  endtask

  task automatic tick(input logic rst_n, input logic kv, input logic [7:0] kc,
                      input logic done, input logic [7:0] res);
    globalReset_n = rst_n;
    key_valid     = kv;
    key_code      = kc;
    cu_done       = done;
    cu_result     = res;
    @(posedge clock);
    cyc++;
    model_step(rst_n, kv, kc, done, res);
    #1;
    compare_all();
  endtask

  task automatic press(input int k);
    tick(1'b1, 1'b1, 8'(k), drv_done, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'd0, drv_done, 8'd0);
  endtask

  initial begin
    int hi;
    int r;
    logic [7:0] kc;
    cyc = 0;
    m_phase = 1;
    drv_done = 1'b0;
    model_clear();

    // Reset and idle
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    idle(1);
    check_val("rst_state", 32'(state), 1);
    check_val("rst_operand1", 32'(operand1), 0);
    check_val("rst_result", 32'(result), 0);

    // 12 op 34, assembly length
    press(1); press(2); press(20); press(3); press(4); press(26);
    hi = int'(assembler_en);
    for (int i = 0; i < 19; i++) begin
      idle(1);
      hi += int'(assembler_en);
    end
    check_val("asm_len", hi, ASM_N);
    check_val("dir_operand1", 32'(operand1), 12);
    check_val("dir_operator", 32'(operator), 20);
    check_val("dir_operand2", 32'(operand2), 34);
    check_val("dir_ready", 32'(state), 4);
    check_val("dir_busy", 32'(busy), 0);

    // Run with done after two low cycles
    press(27);
    idle(2);
    check_val("run_cu_en", 32'(control_u_en), 1);
    tick(1'b1, 1'b0, 8'd0, 1'b1, 8'd46);
    check_val("done_cu_en", 32'(control_u_en), 0);
    check_val("done_result", 32'(result), 46);
    check_val("done_state", 32'(state), 6);
    press(5);
    check_val("restart_operand1", 32'(operand1), 5);
    check_val("restart_state", 32'(state), 1);
    check_val("restart_result", 32'(result), 46);

    // Third digit ignored; leading operator ignored
    press(28); press(7); press(8); press(9); press(21);
    check_val("three_digit_op1", 32'(operand1), 78);
    check_val("three_digit_state", 32'(state), 2);
    press(28); press(21);
    check_val("lead_op_state", 32'(state), 1);
    check_val("lead_op_operator", 32'(operator), 0);

    // Timeout with cu_done stuck high
    press(28); press(1); press(20); press(2); press(26);
    idle(ASM_N);
    drv_done = 1'b1;
    press(27);
    idle(CU_TO - 1);
    check_val("pre_timeout_state", 32'(state), 5);
    idle(1);
    check_val("timeout_error", 32'(error), 1);
    check_val("timeout_state", 32'(state), 14);
    drv_done = 1'b0;
    press(28);
    check_val("clr_soft_reset", 32'(soft_reset), 1);
    check_val("clr_error", 32'(error), 0);
    check_val("clr_state", 32'(state), 1);
    idle(1);
    check_val("clr_pulse_end", 32'(soft_reset), 0);

    // Clear in the middle of assembly
    press(1); press(20); press(2); press(26);
    idle(4);
    press(28);
    check_val("abort_asm_en", 32'(assembler_en), 0);
    check_val("abort_operand1", 32'(operand1), 0);
    check_val("abort_operand2", 32'(operand2), 0);

    // Reset and key on the same edge
    tick(1'b0, 1'b1, 8'd1, 1'b0, 8'd0);
    idle(1);
    check_val("rst_key_drop", 32'(operand1), 0);

    // Random key streams
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: kc = 8'($urandom_range(0, 9));
        4:          kc = 8'($urandom_range(20, 23));
        5:          kc = 8'd26;
        6:          kc = 8'd27;
        7:          kc = ($urandom_range(0, 3) == 0) ? 8'd28 : 8'($urandom_range(0, 9));
        default:    kc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(10, 19))
                                                     : 8'($urandom_range(29, 255));
      endcase
      tick(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) != 0), kc,
           ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_sequencer.md
# keypad_sequencer

Registered controller between the PS/2 key decoder and the CPU datapath (assembler, control unit, LCD/7-seg outputs). It turns one-cycle key strobes into two-digit operands and an operator, then sequences the CPU run. Sequencing is assembler enable, then control-unit enable, then result capture. Replaces the ad-hoc delay-counter key handling at CPU top level with an explicit FSM, CPU-completion handshake and timeout.

## Interface

Parameters:

- `Data_WIDTH`, 8: operand/result width.
- `ASM_CYCLES`, 16: cycles `assembler_en` is held high per assembly.
- `CU_TIMEOUT`, 1024: max cycles in RUN without `cu_done` before error.

Ports:

- `clock`  in  1  main 50 MHz clock; all logic on rising edge.
- `globalReset_n`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  one-cycle strobe, one per key press.
- `key_code`  in  8  decoded key.
  - 0–9: digit.
  - 20–23: operator.
  - 26: Enter.
  - 27: `=`.
  - 28: Clear.
  - Valid only with `key_valid`.
- `cu_done`  in  1  control-unit done level.
- `cu_result`  in  Data_WIDTH  control-unit result.
- `operand1`, `operand2`  out  Data_WIDTH  accumulated operands.
- `operator`  out  8  latched operator key code.
- `assembler_en`  out  1  assembler enable; its falling edge hands data downstream.
- `control_u_en`  out  1  control-unit enable.
- `soft_reset`  out  1  one-cycle datapath clear pulse.
- `result`  out  Data_WIDTH  latched CPU result.
- `state`  out  8  state code for 7-seg.
- `busy`  out  1  high in ASM and RUN.
- `error`  out  1  high in ERR.

## Operation

- FSM states and `state` codes: OP1=1, OP2=2, ASM=3, READY=4, RUN=5, DONE=6, ERR=14.
- Reset: all outputs 0, except `state` = 1. FSM enters OP1. Digit counters and timers are cleared.
- Digit entry (OP1 → `operand1`, OP2 → `operand2`):
  - Each operand has its own digit counter, 0..2.
  - Digit with count < 2: operand ← operand×10 + digit; count +1.
  - Digit with count = 2: ignored. Max value 99, so no overflow.
- Operator key in OP1 with count ≥ 1: latch `operator`, go to OP2. With count 0: ignored.
- Enter in OP2 with count ≥ 1: go to ASM. Otherwise ignored.
- ASM: `assembler_en` high for exactly `ASM_CYCLES` cycles, then go to READY.
- `=` in READY: go to RUN. `=` in any other state: ignored.
- RUN:
  - `control_u_en` high throughout.
  - Stale-done guard: `cu_done` is ignored until it has been sampled 0 at least once in RUN (armed).
  - Armed and `cu_done` = 1: `result` ← `cu_result`, go to DONE.
  - Timeout counter reaches `CU_TIMEOUT` first: go to ERR.
- DONE: a digit key clears `operand1`, `operand2` and `operator`, loads the digit as the first digit of `operand1`, and goes to OP1. `result` is held.
- ERR: only Clear or reset leaves it.
- Clear (28), any state:
  - `soft_reset` pulses once.
  - Operands, `operator`, `result`, counters and `error` are cleared.
  - All enables drop; FSM goes to OP1.
  - This aborts ASM or RUN mid-operation.
- Keys in ASM/RUN other than Clear: ignored. Any undefined `key_code`: ignored in all states.
- `key_valid` low: `key_code` is don't-care.

## Timing

- All outputs are registered. A key sampled at edge N is reflected in outputs after edge N.
- `assembler_en`: rises the cycle after Enter is accepted, high exactly `ASM_CYCLES` cycles. `state` = 4 the cycle it falls.
- `control_u_en`: rises the cycle after `=` is accepted. Falls the cycle after the armed `cu_done` is sampled; `result` updates on that same edge.
- ERR entry and `error` rise occur `CU_TIMEOUT` cycles after RUN entry. The counter is not reset by `cu_done` toggling before arming.
- `soft_reset`: exactly 1 cycle, in the cycle after Clear is sampled. Enables are low in that same cycle.
- Simultaneous reset and `key_valid`: reset wins; the key is dropped.
- Two keys on consecutive cycles: both are processed.

## Structure

- Shared package `cpu_keys_pkg`:
  - key constants `KEY_OP_MIN`=20, `KEY_OP_MAX`=23, `KEY_ENTER`=26, `KEY_EQ`=27, `KEY_CLR`=28;
  - FSM state type with the code values above.
  - The CPU top and the LCD block share these.
- One sub-module `operand_accumulator`:
  - two-digit decimal accumulator with digit counter, load/clear/restart inputs;
  - instantiated twice.
- The FSM, ASM/timeout counter and handshake live in `keypad_sequencer`.

## Test plan

- Reset low 3 cycles, then high → all outputs 0, `state` = 1.
- Keys 1, 2, 20, 3, 4, 26 → `operand1` = 12, `operator` = 20, `operand2` = 34. `assembler_en` high exactly 16 cycles, then `state` = 4, `busy` = 0.
- Continue: key 27, with `cu_done` = 0 for 2 cycles then 1 with `cu_result` = 46 → `control_u_en` falls the cycle after `cu_done` is sampled, `result` = 46, `state` = 6. A following key 5 → `operand1` = 5, `state` = 1.
- Keys 7, 8, 9, then 21; a separate case with 21 pressed first → `operand1` = 78 with the third digit ignored. The leading operator is ignored and `state` stays 1.
- Enter RUN with `cu_done` stuck 1 → no capture. After 1024 cycles `error` = 1, `state` = 14. Key 28 → `soft_reset` 1-cycle pulse, `error` = 0, `state` = 1.
- Key 28 mid-ASM (cycle 5) → `assembler_en` low next cycle, operands 0. Reset asserted in the same cycle as `key_valid` with key 1 → `operand1` stays 0.
